// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with start/stop/clear control, driven by 1 kHz / 1 Hz divider outputs sampled as data.
// Four-digit active-low multiplexed 7-segment scan; display outputs are registered one cycle after idx/count.
module stopwatch_core #(
  parameter int SCAN_DP_DIGIT = 2
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       clk_1k,
  input  logic       clk_1s,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       running,
  output logic       wrap
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSE  = 2'd2;
  localparam logic [1:0] DP_IDX = 2'(SCAN_DP_DIGIT);

  logic       k_smp, k_prev, s_smp, s_prev;
  logic       ms_tick, sec_tick, advance;
  logic [1:0] state, state_nxt;
  logic [1:0] idx;
  logic [3:0] s1, s10, m1, m10;
  logic [3:0] cur_digit;

  assign ms_tick  = k_smp & ~k_prev;
  assign sec_tick = s_smp & ~s_prev;
  assign running  = (state == RUN);
  // Only ticks seen while already in RUN count; a clear in the same cycle discards the tick.
  assign advance  = sec_tick && (state == RUN) && !btn_clr;

  always_comb begin
    state_nxt = state;
    if (btn_clr) begin
      state_nxt = IDLE;
    end else if (btn_ss) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    case (idx)
      2'd0:    cur_digit = s1;
      2'd1:    cur_digit = s10;
      2'd2:    cur_digit = m1;
      default: cur_digit = m10;
    endcase
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      k_smp  <= 1'b0;
      k_prev <= 1'b0;
      s_smp  <= 1'b0;
      s_prev <= 1'b0;
      state  <= IDLE;
      idx    <= 2'd0;
      s1     <= 4'd0;
      s10    <= 4'd0;
      m1     <= 4'd0;
      m10    <= 4'd0;
      wrap   <= 1'b0;
      an     <= 4'b1111;
      seg    <= 8'hFF;
    end else begin
      k_smp  <= clk_1k;
      k_prev <= k_smp;
      s_smp  <= clk_1s;
      s_prev <= s_smp;
      state  <= state_nxt;
      wrap   <= 1'b0;
      if (ms_tick) idx <= idx + 2'd1;
      if (btn_clr) begin
        s1  <= 4'd0;
        s10 <= 4'd0;
        m1  <= 4'd0;
        m10 <= 4'd0;
      end else if (advance) begin
        // Ripple carry across BCD digits; 59:59 rolls to 00:00 and flags wrap.
        if (s1 == 4'd9) begin
          s1 <= 4'd0;
          if (s10 == 4'd5) begin
            s10 <= 4'd0;
            if (m1 == 4'd9) begin
              m1 <= 4'd0;
              if (m10 == 4'd5) begin
                m10  <= 4'd0;
                wrap <= 1'b1;
              end else begin
                m10 <= m10 + 4'd1;
              end
            end else begin
              m1 <= m1 + 4'd1;
            end
          end else begin
            s10 <= s10 + 4'd1;
          end
        end else begin
          s1 <= s1 + 4'd1;
        end
      end
      an  <= ~(4'b0001 << idx);
      seg <= {(idx == DP_IDX) ? 1'b0 : 1'b1, seg_code(cur_digit)};
    end
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Stopwatch timekeeping and display stage. It sits directly downstream of the clock divider and consumes its 1 kHz and 1 Hz square-wave outputs as data inputs, sampled in the 100 MHz domain. It keeps an MM:SS BCD count (00:00–59:59) under start/stop/clear control. It multiplexes the four digits onto an active-low common-anode 7-segment display.

Parameters:
SCAN_DP_DIGIT, 2, index of the digit whose decimal point is lit as the MM.SS separator (0..3).

Ports:
clk_100M  input  1  system clock, 100 MHz; the only clock.
rst  input  1  synchronous, active-low reset; sampled on the clk_100M rising edge.
clk_1k  input  1  1 kHz square wave from the divider; treated as data, never as a clock.
clk_1s  input  1  1 Hz square wave from the divider; treated as data, never as a clock.
btn_ss  input  1  start/stop request; debounced single-cycle pulse.
btn_clr  input  1  clear request; debounced single-cycle pulse.
an  output  4  digit enables, active-low; an[0] is the rightmost digit.
seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g..a.
running  output  1  high while the FSM is in RUN.
wrap  output  1  one-cycle pulse when the count rolls from 59:59 to 00:00.

Behaviour:
- Tick extraction:
  - clk_1k and clk_1s each pass through one sampling register; previous-sample registers reset to 0.
  - ms_tick = sampled & ~prev, giving one cycle per rising edge. sec_tick is derived the same way from clk_1s.
  - Latency from input edge to tick is 2 cycles. Falling edges produce no tick.
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE.
  - IDLE + btn_ss -> RUN.
  - RUN + btn_ss -> PAUSE.
  - PAUSE + btn_ss -> RUN.
  - btn_clr in any state -> IDLE and count forced to 00:00.
  - btn_clr and btn_ss in the same cycle: clear wins; next state is IDLE.
- Counting:
  - The count advances only on sec_tick while the current state is RUN.
  - sec_tick in the same cycle as RUN->PAUSE is counted.
  - sec_tick in the same cycle as IDLE->RUN or PAUSE->RUN is not counted.
  - sec_tick in the same cycle as btn_clr is discarded.
- BCD rules: s1 0..9, s10 0..5, m1 0..9, m10 0..5.
  - Each digit carries to the next when it passes its limit.
  - 59:59 + tick -> 00:00, wrap=1 for exactly that one cycle; the FSM stays in RUN.
  - No binary arithmetic is used; out-of-range digit values are unreachable.
- Scan:
  - 2-bit idx increments (mod 4) on every ms_tick, in all states.
  - idx mapping: 0->s1, 1->s10, 2->m1, 3->m10.
  - an and seg are registered from idx and the current count, one cycle after idx or count change. an = ~(4'b0001 << idx).
- Segment codes (seg[6:0], active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - seg[7]=0 only when idx==SCAN_DP_DIGIT, otherwise 1.
- Reset values:
  - an=4'b1111, seg=8'hFF, running=0, wrap=0, idx=0, count=00:00, state IDLE.
  - Reset asserted mid-run returns everything to these values at the next clock edge; pending ticks are dropped.
- Display updates in IDLE and PAUSE as well; digits keep scanning whatever the FSM state.

Test Plan:
- Reset then release with clk_1k toggling every 10 cycles -> first cycle after release an=1111, seg=FF. Then an cycles 1110,1101,1011,0111,1110 on successive ms_ticks; dp (seg[7]=0) appears only with an=1011.
- btn_ss pulse, then 12 clk_1s rising edges (toggle every 40 cycles) -> running=1, count 00:12. Digit0 shows seg[6:0]=0100100; digit1 shows 1111001.
- Preload to 59:58 via 3598 ticks (fast clk_1s), then 2 further ticks -> 59:59, then 00:00. wrap high exactly one cycle; running stays 1.
- In RUN at 00:05, btn_ss in the same cycle as sec_tick -> state PAUSE, count 00:06. Further ticks leave it at 00:06; btn_ss again resumes counting.
- btn_clr and btn_ss in the same cycle during RUN at 03:27 -> IDLE, running=0, count 00:00. A sec_tick in the same cycle is ignored.
- rst low for one cycle during RUN at 10:00 -> all outputs at reset values next cycle, state IDLE. Later ticks do not count until btn_ss.
